axis_fifo_width_converter: RTL and testbench
============================================

AXIS_FIFO_WIDTH_CONVERTER -- requirements
Module: axis_fifo_width_converter

Interface
REQ-001 Param DEPTH, 16: FIFO depth in entries of the wider bus width; power of 2, >=2.
REQ-002 Param S_DATA_WIDTH, 8: input tdata width in bits.
REQ-003 Param M_DATA_WIDTH, 32: output tdata width in bits.
REQ-004 Param BYTE_SIZE, 8: lane width; S_KEEP_WIDTH=S_DATA_WIDTH/BYTE_SIZE, M_KEEP_WIDTH=M_DATA_WIDTH/BYTE_SIZE.
REQ-005 Param USER_WIDTH, 1: tuser width.
REQ-006 clk  in  1  single clock, all logic rising-edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low; synchronous deassert to clk.
REQ-008 s_axis_tdata/tkeep/tvalid/tlast/tuser  in  S_DATA_WIDTH/S_KEEP_WIDTH/1/1/USER_WIDTH  input stream.
REQ-009 s_axis_tready  out  1  input accept.
REQ-010 m_axis_tdata/tkeep/tvalid/tlast/tuser  out  M_DATA_WIDTH/M_KEEP_WIDTH/1/1/USER_WIDTH  output stream.
REQ-011 m_axis_tready  in  1  output accept.
REQ-012 status_depth  out  clog2(DEPTH)+1  current FIFO occupancy in entries.

Function
REQ-013 Transfer occurs on a cycle where tvalid&tready are high at a clock edge; the converter SHALL NOT drop, duplicate or reorder lanes.
REQ-014 Width ratio SHALL be an integer power of 2; S_DATA_WIDTH and M_DATA_WIDTH SHALL be multiples of BYTE_SIZE; violations stop elaboration with an error.
REQ-015 M wider (upsize): packer before FIFO; first input beat occupies lowest lanes, next beat next-higher lanes, and so on.
REQ-016 Upsize: packed word is pushed when all segments filled or on an input beat with tlast=1; unfilled segments carry tdata=0 and tkeep=0; tlast of the wide word = input tlast; tuser = tuser of the final input beat.
REQ-017 S wider (downsize): unpacker after FIFO emits wide word as segments, lowest lanes first.
REQ-018 Downsize: segments after the last segment with any nonzero tkeep bit are skipped; tlast asserted only on the final emitted segment of a word with tlast=1; tuser replicated on every segment.
REQ-019 Equal widths: no converter; stream passes straight through the FIFO.
REQ-020 FIFO stores data, keep, last, user per entry; circular buffer with clog2(DEPTH)+1-bit read/write pointers, wrap on power-of-2 boundary.
REQ-021 FIFO full when occupancy=DEPTH: FIFO input tready=0; full computed from registered pointers, so a write while full is refused even if a read happens the same cycle.
REQ-022 FIFO empty: output tvalid=0; a word written at edge N is presented on the FIFO output at edge N+1 at earliest (one-cycle latency, first-word fall-through thereafter).
REQ-023 Simultaneous read and write when neither full nor empty: both complete, occupancy unchanged.
REQ-024 Output data/keep/last/user SHALL be held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 status_depth updates the cycle after each push/pop.
REQ-026 Converter stages have at most one register stage each; sustained throughput one narrow beat per cycle with tready held high.

Reset
REQ-027 While rst_n=0: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata/tkeep/tuser=0, status_depth=0, FIFO pointers and packer/unpacker state cleared; s_axis_tready=0.
REQ-028 First cycle after rst_n deasserts: s_axis_tready=1; any partially packed word or partially emitted word at reset is discarded.

Verification
REQ-029 S=8,M=32: send 0x11,0x22,0x33,0x44 (tlast on 0x44) -> one output beat tdata=0x44332211, tkeep=0xF, tlast=1.
REQ-030 S=8,M=32: send 0xAA,0xBB (tlast on 0xBB) -> tdata=0x0000BBAA, tkeep=0x3, tlast=1.
REQ-031 S=32,M=8: send 0x44332211 keep=0xF tlast=1 -> beats 0x11,0x22,0x33,0x44, tlast only on 0x44; then 0x0000BBAA keep=0x3 tlast=1 -> beats 0xAA,0xBB, tlast on 0xBB.
REQ-032 DEPTH=16, m_axis_tready=0, push 16 wide entries -> status_depth=16, s_axis_tready=0; one pop -> status_depth=15, s_axis_tready=1 next cycle.
REQ-033 Random tvalid/tready toggling over 1000 beats -> output byte stream identical to input, tlast boundaries preserved.
REQ-034 rst_n pulsed low mid-frame with 5 entries stored -> m_axis_tvalid=0 and status_depth=0 immediately; new frame afterwards transfers correctly.

Source files
------------

// File: rtl/axis_fifo_width_converter.sv
// AXI-Stream FIFO with width conversion between an S-side and an M-side bus.
// Upsizing packs narrow beats into a wide word before the FIFO. Downsizing
// unpacks wide words into narrow segments after the FIFO. Equal widths pass
// straight through the FIFO. The FIFO always stores entries of the wider width.
module axis_fifo_width_converter #(
  parameter int DEPTH        = 16,
  parameter int S_DATA_WIDTH = 8,
  parameter int M_DATA_WIDTH = 32,
  parameter int BYTE_SIZE    = 8,
  parameter int USER_WIDTH   = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [S_DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [S_DATA_WIDTH/BYTE_SIZE-1:0]  s_axis_tkeep,
  input  logic                               s_axis_tvalid,
  input  logic                               s_axis_tlast,
  input  logic [USER_WIDTH-1:0]              s_axis_tuser,
  output logic                               s_axis_tready,
  output logic [M_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [M_DATA_WIDTH/BYTE_SIZE-1:0]  m_axis_tkeep,
  output logic                               m_axis_tvalid,
  output logic                               m_axis_tlast,
  output logic [USER_WIDTH-1:0]              m_axis_tuser,
  input  logic                               m_axis_tready,
  output logic [$clog2(DEPTH):0]             status_depth
);

  localparam int WIDE        = (S_DATA_WIDTH > M_DATA_WIDTH) ? S_DATA_WIDTH : M_DATA_WIDTH;
  localparam int NARROW      = (S_DATA_WIDTH > M_DATA_WIDTH) ? M_DATA_WIDTH : S_DATA_WIDTH;
  localparam int WIDE_KEEP   = WIDE / BYTE_SIZE;
  localparam int NARROW_KEEP = NARROW / BYTE_SIZE;
  localparam int RATIO       = WIDE / NARROW;
  localparam int SEG_W       = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int ADDR_W      = $clog2(DEPTH);
  localparam int PTR_W       = ADDR_W + 1;
  localparam int ENTRY_W     = WIDE + WIDE_KEEP + 1 + USER_WIDTH;

  // Elaboration-time parameter sanity.
  if ((S_DATA_WIDTH % BYTE_SIZE) != 0 || (M_DATA_WIDTH % BYTE_SIZE) != 0) begin : g_bad_lanes
    $error("data widths must be multiples of BYTE_SIZE");
  end
  if ((WIDE % NARROW) != 0 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("width ratio must be an integer power of 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of 2 and at least 2");
  end

  // FIFO-side streams, always WIDE bits.
  logic [WIDE-1:0]       fifo_in_data,  fifo_out_data;
  logic [WIDE_KEEP-1:0]  fifo_in_keep,  fifo_out_keep;
  logic                  fifo_in_last,  fifo_out_last;
  logic [USER_WIDTH-1:0] fifo_in_user,  fifo_out_user;
  logic                  fifo_in_valid, fifo_out_valid;
  logic                  fifo_in_ready, fifo_out_ready;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               full, empty, fifo_push, fifo_pop;

  // Full/empty come from registered pointers only, so a pop never frees a
  // slot for a push in the same cycle.
  assign full      = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign fifo_in_ready  = !full;
  assign fifo_out_valid = !empty;
  assign fifo_push = fifo_in_valid && fifo_in_ready;
  assign fifo_pop  = fifo_out_valid && fifo_out_ready;
  assign s_axis_tready = rst_n && fifo_in_ready;
  assign status_depth  = wr_ptr - rd_ptr;

  // Head entry is forced to zero while empty, so outputs read zero in reset.
  assign {fifo_out_data, fifo_out_keep, fifo_out_last, fifo_out_user} =
      empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

  // Storage write.
  // NOTE: the storage array has no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {fifo_in_data, fifo_in_keep, fifo_in_last, fifo_in_user};
    end
  end

  // Read/write pointer advance.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  if (M_DATA_WIDTH > S_DATA_WIDTH) begin : g_upsize
    logic [WIDE-1:0]      pack_data, merged_data;
    logic [WIDE_KEEP-1:0] pack_keep, merged_keep;
    logic [SEG_W-1:0]     pack_seg;
    logic                 pack_final;

    // Merge the incoming beat into the lane slot selected by pack_seg.
    // NOTE: defaults first in always_comb so no path leaves a variable unassigned (no latch).
    always_comb begin
      merged_data = pack_data;
      merged_keep = pack_keep;
      for (int i = 0; i < RATIO; i++) begin
        if (pack_seg == SEG_W'(i)) begin
          merged_data[i*NARROW +: NARROW]           = s_axis_tdata;
          merged_keep[i*NARROW_KEEP +: NARROW_KEEP] = s_axis_tkeep;
        end
      end
    end

    assign pack_final    = s_axis_tlast || (pack_seg == SEG_W'(RATIO - 1));
    assign fifo_in_valid = s_axis_tvalid && pack_final;
    assign fifo_in_data  = merged_data;
    assign fifo_in_keep  = merged_keep;
    assign fifo_in_last  = s_axis_tlast;
    assign fifo_in_user  = s_axis_tuser;

    // Accumulate partial words; clear once the word is handed to the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pack_data <= '0;
        pack_keep <= '0;
        pack_seg  <= '0;
      end else if (s_axis_tvalid && s_axis_tready) begin
        if (pack_final) begin
          pack_data <= '0;
          pack_keep <= '0;
          pack_seg  <= '0;
        end else begin
          pack_data <= merged_data;
          pack_keep <= merged_keep;
          pack_seg  <= pack_seg + SEG_W'(1);
        end
      end
    end

    assign m_axis_tdata   = fifo_out_data;
    assign m_axis_tkeep   = fifo_out_keep;
    assign m_axis_tvalid  = fifo_out_valid;
    assign m_axis_tlast   = fifo_out_last;
    assign m_axis_tuser   = fifo_out_user;
    assign fifo_out_ready = m_axis_tready;

  end else if (S_DATA_WIDTH > M_DATA_WIDTH) begin : g_downsize
    logic [SEG_W-1:0] unpack_seg, last_seg;
    logic             seg_done;

    assign fifo_in_valid = s_axis_tvalid;
    assign fifo_in_data  = s_axis_tdata;
    assign fifo_in_keep  = s_axis_tkeep;
    assign fifo_in_last  = s_axis_tlast;
    assign fifo_in_user  = s_axis_tuser;

    // Select the current segment and find the last segment holding any kept lane.
    always_comb begin
      m_axis_tdata = '0;
      m_axis_tkeep = '0;
      last_seg     = '0;
      for (int i = 0; i < RATIO; i++) begin
        if (|fifo_out_keep[i*NARROW_KEEP +: NARROW_KEEP]) last_seg = SEG_W'(i);
        if (unpack_seg == SEG_W'(i)) begin
          m_axis_tdata = fifo_out_data[i*NARROW +: NARROW];
          m_axis_tkeep = fifo_out_keep[i*NARROW_KEEP +: NARROW_KEEP];
        end
      end
    end

    assign seg_done       = (unpack_seg == last_seg);
    assign m_axis_tvalid  = fifo_out_valid;
    assign m_axis_tlast   = fifo_out_last && seg_done;
    assign m_axis_tuser   = fifo_out_user;
    assign fifo_out_ready = m_axis_tready && seg_done;

    // Step through segments; the word leaves the FIFO with its final segment.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        unpack_seg <= '0;
      end else if (m_axis_tvalid && m_axis_tready) begin
        unpack_seg <= seg_done ? '0 : unpack_seg + SEG_W'(1);
      end
    end

  end else begin : g_passthrough
    assign fifo_in_valid  = s_axis_tvalid;
    assign fifo_in_data   = s_axis_tdata;
    assign fifo_in_keep   = s_axis_tkeep;
    assign fifo_in_last   = s_axis_tlast;
    assign fifo_in_user   = s_axis_tuser;
    assign m_axis_tdata   = fifo_out_data;
    assign m_axis_tkeep   = fifo_out_keep;
    assign m_axis_tvalid  = fifo_out_valid;
    assign m_axis_tlast   = fifo_out_last;
    assign m_axis_tuser   = fifo_out_user;
    assign fifo_out_ready = m_axis_tready;
  end

endmodule

// File: tb/tb_axis_fifo_width_converter.sv
// Directed bench for the width-converting FIFO: an 8->32 upsizer and a
// 32->8 downsizer instance, sharing clock and reset.
module tb_axis_fifo_width_converter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Upsizer 8 -> 32
  logic [7:0]  up_s_tdata;
  logic [0:0]  up_s_tkeep;
  logic        up_s_tvalid, up_s_tlast, up_s_tready;
  logic [0:0]  up_s_tuser;
  logic [31:0] up_m_tdata;
  logic [3:0]  up_m_tkeep;
  logic        up_m_tvalid, up_m_tlast, up_m_tready;
  logic [0:0]  up_m_tuser;
  logic [4:0]  up_depth;

  // Downsizer 32 -> 8
  logic [31:0] dn_s_tdata;
  logic [3:0]  dn_s_tkeep;
  logic        dn_s_tvalid, dn_s_tlast, dn_s_tready;
  logic [0:0]  dn_s_tuser;
  logic [7:0]  dn_m_tdata;
  logic [0:0]  dn_m_tkeep;
  logic        dn_m_tvalid, dn_m_tlast, dn_m_tready;
  logic [0:0]  dn_m_tuser;
  logic [4:0]  dn_depth;

  axis_fifo_width_converter #(
    .DEPTH(16), .S_DATA_WIDTH(8), .M_DATA_WIDTH(32), .BYTE_SIZE(8), .USER_WIDTH(1)
  ) dut_up (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(up_s_tdata), .s_axis_tkeep(up_s_tkeep), .s_axis_tvalid(up_s_tvalid),
    .s_axis_tlast(up_s_tlast), .s_axis_tuser(up_s_tuser), .s_axis_tready(up_s_tready),
    .m_axis_tdata(up_m_tdata), .m_axis_tkeep(up_m_tkeep), .m_axis_tvalid(up_m_tvalid),
    .m_axis_tlast(up_m_tlast), .m_axis_tuser(up_m_tuser), .m_axis_tready(up_m_tready),
    .status_depth(up_depth)
  );

  axis_fifo_width_converter #(
    .DEPTH(16), .S_DATA_WIDTH(32), .M_DATA_WIDTH(8), .BYTE_SIZE(8), .USER_WIDTH(1)
  ) dut_dn (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(dn_s_tdata), .s_axis_tkeep(dn_s_tkeep), .s_axis_tvalid(dn_s_tvalid),
    .s_axis_tlast(dn_s_tlast), .s_axis_tuser(dn_s_tuser), .s_axis_tready(dn_s_tready),
    .m_axis_tdata(dn_m_tdata), .m_axis_tkeep(dn_m_tkeep), .m_axis_tvalid(dn_m_tvalid),
    .m_axis_tlast(dn_m_tlast), .m_axis_tuser(dn_m_tuser), .m_axis_tready(dn_m_tready),
    .status_depth(dn_depth)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic send_up(input logic [7:0] d, input logic l, input logic u);
    up_s_tdata = d; up_s_tkeep = 1'b1; up_s_tlast = l; up_s_tuser = u; up_s_tvalid = 1'b1;
    for (int n = 0; n < 200 && !up_s_tready; n++) @(negedge clk);
    if (!up_s_tready) check("up_send_ready", up_s_tready, 1);
    @(negedge clk);
    up_s_tvalid = 1'b0;
  endtask

  task automatic recv_up(input string tag, input logic [31:0] d, input logic [3:0] k,
                         input logic l, input logic u);
    up_m_tready = 1'b1;
    for (int n = 0; n < 200 && !up_m_tvalid; n++) @(negedge clk);
    if (!up_m_tvalid) check({tag, "_valid"}, up_m_tvalid, 1);
    check(tag, {up_m_tuser, up_m_tlast, up_m_tkeep, up_m_tdata}, {u, l, k, d});
    @(negedge clk);
    up_m_tready = 1'b0;
  endtask

  task automatic send_dn(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    dn_s_tdata = d; dn_s_tkeep = k; dn_s_tlast = l; dn_s_tuser = u; dn_s_tvalid = 1'b1;
    for (int n = 0; n < 200 && !dn_s_tready; n++) @(negedge clk);
    if (!dn_s_tready) check("dn_send_ready", dn_s_tready, 1);
    @(negedge clk);
    dn_s_tvalid = 1'b0;
  endtask

  task automatic recv_dn(input string tag, input logic [7:0] d, input logic k,
                         input logic l, input logic u);
    dn_m_tready = 1'b1;
    for (int n = 0; n < 200 && !dn_m_tvalid; n++) @(negedge clk);
    if (!dn_m_tvalid) check({tag, "_valid"}, dn_m_tvalid, 1);
    check(tag, {dn_m_tuser, dn_m_tlast, dn_m_tkeep, dn_m_tdata}, {u, l, k, d});
    @(negedge clk);
    dn_m_tready = 1'b0;
  endtask

  localparam int N_RAND = 1000;
  logic [7:0]  rnd_data [N_RAND];
  logic        rnd_last [N_RAND];
  logic [37:0] exp_q [$];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int total, got;
    logic [31:0] acc;
    logic [3:0]  acc_keep;
    int pos;

    up_s_tdata = '0; up_s_tkeep = '0; up_s_tvalid = 0; up_s_tlast = 0; up_s_tuser = '0;
    up_m_tready = 0;
    dn_s_tdata = '0; dn_s_tkeep = '0; dn_s_tvalid = 0; dn_s_tlast = 0; dn_s_tuser = '0;
    dn_m_tready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_up_m_valid", up_m_tvalid, 0);
    check("rst_up_m_data", {up_m_tuser, up_m_tlast, up_m_tkeep, up_m_tdata}, 0);
    check("rst_up_depth", up_depth, 0);
    check("rst_up_s_ready", up_s_tready, 0);
    check("rst_dn_s_ready", dn_s_tready, 0);
    check("rst_dn_m_valid", dn_m_tvalid, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_up_s_ready", up_s_tready, 1);
    check("post_rst_dn_s_ready", dn_s_tready, 1);
    @(negedge clk);

    // Upsize: full word, partial word with tuser from final beat, word split without tlast
    send_up(8'h11, 0, 0); send_up(8'h22, 0, 0); send_up(8'h33, 0, 0); send_up(8'h44, 1, 1);
    recv_up("pack_full", 32'h44332211, 4'hF, 1, 1);
    send_up(8'hAA, 0, 1); send_up(8'hBB, 1, 0);
    recv_up("pack_partial", 32'h0000BBAA, 4'h3, 1, 0);
    send_up(8'h01, 0, 0); send_up(8'h02, 0, 0); send_up(8'h03, 0, 0); send_up(8'h04, 0, 0);
    send_up(8'h05, 1, 0);
    recv_up("pack_nolast", 32'h04030201, 4'hF, 0, 0);
    recv_up("pack_tail", 32'h00000005, 4'h1, 1, 0);

    // Fill to DEPTH, hold under backpressure, refuse write-while-full on a pop cycle
    for (int i = 0; i < 16; i++) send_up(8'(i + 1), 1, 0);
    check("full_depth", up_depth, 16);
    check("full_s_ready", up_s_tready, 0);
    check("full_head", {up_m_tvalid, up_m_tdata}, {1'b1, 32'h00000001});
    @(negedge clk);
    check("stall_hold", {up_m_tlast, up_m_tkeep, up_m_tdata}, {1'b1, 4'h1, 32'h00000001});
    up_s_tdata = 8'hEE; up_s_tkeep = 1'b1; up_s_tlast = 1; up_s_tvalid = 1; up_m_tready = 1;
    @(negedge clk);
    up_s_tvalid = 0; up_m_tready = 0;
    check("pop_depth", up_depth, 15);
    check("pop_s_ready", up_s_tready, 1);
    for (int i = 1; i < 16; i++) recv_up("drain", 32'(i + 1), 4'h1, 1, 0);
    check("drain_depth", up_depth, 0);
    check("drain_valid", up_m_tvalid, 0);

    // Downsize: full word, partial keep, sparse keep, word without tlast
    send_dn(32'h44332211, 4'hF, 1, 1);
    send_dn(32'h0000BBAA, 4'h3, 1, 0);
    send_dn(32'h00CC0000, 4'h4, 1, 1);
    send_dn(32'h88776655, 4'hF, 0, 0);
    check("dn_depth", dn_depth, 4);
    recv_dn("dn_w0_b0", 8'h11, 1, 0, 1); recv_dn("dn_w0_b1", 8'h22, 1, 0, 1);
    recv_dn("dn_w0_b2", 8'h33, 1, 0, 1); recv_dn("dn_w0_b3", 8'h44, 1, 1, 1);
    recv_dn("dn_w1_b0", 8'hAA, 1, 0, 0); recv_dn("dn_w1_b1", 8'hBB, 1, 1, 0);
    recv_dn("dn_w2_b0", 8'h00, 0, 0, 1); recv_dn("dn_w2_b1", 8'h00, 0, 0, 1);
    recv_dn("dn_w2_b2", 8'hCC, 1, 1, 1);
    recv_dn("dn_w3_b0", 8'h55, 1, 0, 0); recv_dn("dn_w3_b1", 8'h66, 1, 0, 0);
    recv_dn("dn_w3_b2", 8'h77, 1, 0, 0); recv_dn("dn_w3_b3", 8'h88, 1, 0, 0);
    check("dn_empty_valid", dn_m_tvalid, 0);
    check("dn_empty_depth", dn_depth, 0);

    // Reset mid-frame with 5 entries stored plus a partial word
    for (int i = 0; i < 5; i++) send_up(8'h70 + 8'(i), 1, 0);
    send_up(8'h99, 0, 0);
    check("pre_rst_depth", up_depth, 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", up_m_tvalid, 0);
    check("mid_rst_depth", up_depth, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_up(8'h55, 0, 0); send_up(8'h66, 1, 0);
    recv_up("post_rst_frame", 32'h00006655, 4'h3, 1, 0);

    // Random valid/ready traffic against a packing model
    for (int i = 0; i < N_RAND; i++) begin
      rnd_data[i] = 8'($urandom);
      rnd_last[i] = (i == N_RAND - 1) || ($urandom_range(0, 4) == 0);
    end
    acc = '0; acc_keep = '0; pos = 0;
    for (int i = 0; i < N_RAND; i++) begin
      acc[8*pos +: 8] = rnd_data[i];
      acc_keep[pos] = 1'b1;
      pos++;
      if (rnd_last[i] || pos == 4) begin
        exp_q.push_back({1'b0, rnd_last[i], acc_keep, acc});
        acc = '0; acc_keep = '0; pos = 0;
      end
    end
    total = exp_q.size();
    got = 0;
    fork
      begin
        for (int i = 0; i < N_RAND; i++) begin
          while ($urandom_range(0, 3) == 0) @(negedge clk);
          send_up(rnd_data[i], rnd_last[i], 0);
        end
      end
      begin
        for (int c = 0; c < 20000 && got < total; c++) begin
          @(negedge clk);
          up_m_tready = 1'($urandom_range(0, 1));
          if (up_m_tvalid && up_m_tready) begin
            check("rand_word", {up_m_tuser, up_m_tlast, up_m_tkeep, up_m_tdata}, exp_q.pop_front());
            got++;
          end
        end
        @(negedge clk);
        up_m_tready = 1'b0;
      end
    join
    check("rand_count", got, total);
    check("rand_end_depth", up_depth, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
